// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops plus an iterative SHLN that walks one bit per cycle.
// Results land in a valid/ready output register with an accumulating overflow flag.
module alu_pipe #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CONST_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   alu_rs1,
  input  logic [WIDTH-1:0]   alu_rs2,
  input  logic [CONST_W-1:0] constant,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   aluOut,
  output logic               overflow,
  output logic               sticky_ovf,
  input  logic               clr_sticky
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_ADDI = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_SHL  = 4'b0011,
    OP_LT   = 4'b0100,
    OP_EQ0  = 4'b0101,
    OP_CMP  = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_AND  = 4'b1000,
    OP_OR   = 4'b1001,
    OP_NOT  = 4'b1010,
    OP_SHLN = 4'b1011
  } op_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SH_W-1:0]  cnt;
  logic             ovf_acc;

  op_t              op;
  logic [SH_W-1:0]  n;
  logic [WIDTH-1:0] imm, sum, sumi, diff;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             out_free, accept, start_shift, shift_done, step_ovf;
  logic             wr_en, wr_ovf;
  logic [WIDTH-1:0] wr_data;

  assign op       = op_t'(opcode);
  assign n        = alu_rs2[SH_W-1:0];
  assign imm      = {{(WIDTH-CONST_W){constant[CONST_W-1]}}, constant};
  assign sum      = alu_rs1 + alu_rs2;
  assign sumi     = alu_rs1 + imm;
  assign diff     = alu_rs1 - alu_rs2;

  assign out_free    = !out_valid || out_ready;
  assign in_ready    = (state == IDLE) && out_free;
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && (op == OP_SHLN) && (n != '0);
  // The last shift step only commits once the output register can take the result.
  assign shift_done  = (state == SHIFT) && (cnt == SH_W'(1)) && out_free;
  assign step_ovf    = work[WIDTH-1] ^ work[WIDTH-2];

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        res     = sum;
        res_ovf = (alu_rs1[WIDTH-1] == alu_rs2[WIDTH-1]) && (sum[WIDTH-1] != alu_rs1[WIDTH-1]);
      end
      OP_ADDI: begin
        res     = sumi;
        res_ovf = (alu_rs1[WIDTH-1] == imm[WIDTH-1]) && (sumi[WIDTH-1] != alu_rs1[WIDTH-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (alu_rs1[WIDTH-1] != alu_rs2[WIDTH-1]) && (diff[WIDTH-1] != alu_rs1[WIDTH-1]);
      end
      OP_SHL: begin
        res     = alu_rs1 << 1;
        res_ovf = alu_rs1[WIDTH-1] ^ alu_rs1[WIDTH-2];
      end
      OP_LT:   res = WIDTH'($signed(alu_rs1) < $signed(alu_rs2));
      OP_EQ0:  res = WIDTH'(alu_rs1 == '0);
      OP_CMP:  res = WIDTH'(alu_rs1[WIDTH-1:WIDTH/2] == alu_rs2[WIDTH-1:WIDTH/2]);
      OP_XOR:  res = alu_rs1 ^ alu_rs2;
      OP_AND:  res = alu_rs1 & alu_rs2;
      OP_OR:   res = alu_rs1 | alu_rs2;
      OP_NOT:  res = ~alu_rs1;
      OP_SHLN: res = alu_rs1;
      default: ;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    wr_ovf  = 1'b0;
    if (shift_done) begin
      wr_en   = 1'b1;
      wr_data = work << 1;
      wr_ovf  = ovf_acc | step_ovf;
    end else if (accept && !start_shift) begin
      wr_en   = 1'b1;
      wr_data = res;
      wr_ovf  = res_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      aluOut     <= '0;
      overflow   <= 1'b0;
      out_valid  <= 1'b0;
      sticky_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_shift) begin
            work    <= alu_rs1;
            cnt     <= n;
            ovf_acc <= 1'b0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != SH_W'(1)) begin
            work    <= work << 1;
            cnt     <= cnt - SH_W'(1);
            ovf_acc <= ovf_acc | step_ovf;
          end else if (out_free) begin
            work  <= work << 1;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (wr_en) begin
        aluOut    <= wr_data;
        overflow  <= wr_ovf;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (wr_en && wr_ovf)
        sticky_ovf <= 1'b1;
      else if (clr_sticky)
        sticky_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a reference model queues expected results at issue time.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       clr_sticky = 1'b0;
  logic [3:0] opcode = '0;
  logic [7:0] alu_rs1 = '0;
  logic [7:0] alu_rs2 = '0;
  logic [1:0] constant = '0;
  logic       in_ready, out_valid, overflow, sticky_ovf;
  logic [7:0] aluOut;

  int checks = 0;
  int errors = 0;
  logic [8:0] sb_q[$];

  alu_pipe #(.WIDTH(8), .CONST_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .constant(constant),
    .out_valid(out_valid), .out_ready(out_ready), .aluOut(aluOut),
    .overflow(overflow), .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  // Returns {overflow, result}.
  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] c);
    int sa = $signed(a);
    int sb = $signed(b);
    int sc = $signed(c);
    int s = 0;
    logic [7:0] r = '0;
    logic o = 1'b0;
    case (op)
      4'h0: begin s = sa + sb; r = s[7:0]; o = (s > 127) || (s < -128); end
      4'h1: begin s = sa + sc; r = s[7:0]; o = (s > 127) || (s < -128); end
      4'h2: begin s = sa - sb; r = s[7:0]; o = (s > 127) || (s < -128); end
      4'h3: begin r = {a[6:0], 1'b0}; o = (a[7] != a[6]); end
      4'h4: r = (sa < sb) ? 8'd1 : 8'd0;
      4'h5: r = (a == 8'd0) ? 8'd1 : 8'd0;
      4'h6: r = (a[7:4] == b[7:4]) ? 8'd1 : 8'd0;
      4'h7: r = a ^ b;
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = ~a;
      4'hB: begin
        r = a;
        for (int i = 0; i < int'(b[2:0]); i++) begin
          if (r[7] != r[6]) o = 1'b1;
          r = {r[6:0], 1'b0};
        end
      end
      default: begin r = 8'd0; o = 1'b0; end
    endcase
    return {o, r};
  endfunction

  // Drives one request and returns 1 time unit after its accept edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [1:0] c);
    int waited = 0;
    opcode = op; alu_rs1 = a; alu_rs2 = b; constant = c; in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(model(op, a, b, c));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || aluOut !== 8'h00 || overflow !== 1'b0 || sticky_ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: valid=%0b out=%h ovf=%0b sticky=%0b required 0 00 0 0",
               out_valid, aluOut, overflow, sticky_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b valid=%0b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ops();
    logic [3:0] ops [19] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'h5, 4'h5, 4'h6,
                             4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hF, 4'h1};
    logic [7:0] as  [19] = '{8'h04, 8'h04, 8'h80, 8'h40, 8'h21, 8'h01, 8'h84, 8'h00, 8'h10, 8'h00,
                             8'h00, 8'hA5, 8'hA5, 8'hA0, 8'h00, 8'h55, 8'hFF, 8'hFF, 8'h7F};
    logic [7:0] bs  [19] = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h84, 8'h01, 8'h00, 8'h00, 8'h40,
                             8'h00, 8'h0F, 8'h0F, 8'h0F, 8'h00, 8'h08, 8'hFF, 8'hFF, 8'h00};
    logic [1:0] cs  [19] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b01};
    logic [8:0] exp;
    for (int i = 0; i < 19; i++) begin
      issue(ops[i], as[i], bs[i], cs[i]);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
      checks++;
      if (out_valid !== 1'b1 || {overflow, aluOut} !== exp) begin
        errors++;
        $display("FAIL op_vec%0d (op=%h a=%h b=%h): valid=%0b ovf=%0b out=%h required 1 %0b %h",
                 i, ops[i], as[i], bs[i], out_valid, overflow, aluOut, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_shln(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] exp;
    issue(4'hB, a, b, 2'b00);
    for (int i = 0; i < int'(b[2:0]); i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL shln_busy a=%h n=%0d cyc%0d: in_ready=%0b valid=%0b required 0 0",
                 a, b[2:0], i, in_ready, out_valid);
      end
      @(posedge clk); #1;
    end
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    checks++;
    if (out_valid !== 1'b1 || {overflow, aluOut} !== exp || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL shln_result a=%h n=%0d: valid=%0b ovf=%0b out=%h in_ready=%0b required 1 %0b %h 1",
               a, b[2:0], out_valid, overflow, aluOut, in_ready, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_sticky();
    logic [8:0] exp;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear0: sticky=%0b required 0", sticky_ovf);
    end
    issue(4'h0, 8'h7F, 8'h01, 2'b00);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    checks++;
    if ({overflow, aluOut} !== exp || sticky_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set: ovf=%0b out=%h sticky=%0b required %0b %h 1",
               overflow, aluOut, sticky_ovf, exp[8], exp[7:0]);
    end
    issue(4'h0, 8'h01, 8'h01, 2'b00);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp !== 9'h002 || sticky_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold: sticky=%0b required 1", sticky_ovf);
    end
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear1: sticky=%0b required 0", sticky_ovf);
    end
    // Clear held across an overflowing write: the set must win.
    clr_sticky = 1'b1;
    issue(4'h0, 8'h80, 8'h80, 2'b00);
    clr_sticky = 1'b0;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    checks++;
    if ({overflow, aluOut} !== exp || sticky_ovf !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set_wins: ovf=%0b out=%h sticky=%0b required %0b %h 1",
               overflow, aluOut, sticky_ovf, exp[8], exp[7:0]);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp;
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(4'h0, 8'h10, 8'h20, 2'b00);
    opcode = 4'h7; alu_rs1 = 8'h3C; alu_rs2 = 8'hFF; constant = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = (sb_q.size() != 0) ? sb_q[0] : 9'h1FF;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || {overflow, aluOut} !== exp) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: in_ready=%0b valid=%0b ovf=%0b out=%h required 0 1 %0b %h",
                 i, in_ready, out_valid, overflow, aluOut, exp[8], exp[7:0]);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready: in_ready=%0b required 1", in_ready);
    end
    sb_q.push_back(model(4'h7, 8'h3C, 8'hFF, 2'b00));
    exp = sb_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || {overflow, aluOut} !== exp) begin
      errors++;
      $display("FAIL bp_first: valid=%0b ovf=%0b out=%h required 1 %0b %h",
               out_valid, overflow, aluOut, exp[8], exp[7:0]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    checks++;
    if (out_valid !== 1'b1 || {overflow, aluOut} !== exp) begin
      errors++;
      $display("FAIL bp_second: valid=%0b ovf=%0b out=%h required 1 %0b %h",
               out_valid, overflow, aluOut, exp[8], exp[7:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL bp_drain: valid=%0b pending=%0d required 0 0", out_valid, sb_q.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    logic stray = 1'b0;
    issue(4'hB, 8'h81, 8'h07, 2'b00);
    // The shift is aborted by reset, so its queued result never appears.
    if (sb_q.size() != 0) void'(sb_q.pop_back());
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sticky_ovf !== 1'b0 || aluOut !== 8'h00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: valid=%0b sticky=%0b out=%h ovf=%0b required 0 0 00 0",
               out_valid, sticky_ovf, aluOut, overflow);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_release: in_ready=%0b valid=%0b required 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (stray !== 1'b0 || sticky_ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_stray: stray=%0b sticky=%0b required 0 0", stray, sticky_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_shln(8'h03, 8'h03);
    test_shln(8'h21, 8'h02);
    test_shln(8'h01, 8'h07);
    test_sticky();
    test_backpressure();
    test_reset_mid_shift();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: pending=%0d required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits; SHALL be an even value >= 4.
REQ-002 Parameter CONST_W, default 2, width of the signed immediate.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  active-low reset, asserted asynchronously, released synchronously to clk.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 opcode  input  4  operation select.
REQ-008 alu_rs1, alu_rs2  input  WIDTH each  operands.
REQ-009 constant  input  CONST_W  signed immediate.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 aluOut  output  WIDTH  registered result.
REQ-013 overflow  output  1  registered overflow for the current result.
REQ-014 sticky_ovf  output  1  accumulated overflow.
REQ-015 clr_sticky  input  1  clears sticky_ovf.

Function
REQ-016 Accept when in_valid && in_ready at a rising clk edge; in_ready SHALL be 1 only in IDLE && (!out_valid || out_ready).
REQ-017 Opcodes: 0000 ADD rs1+rs2; 0001 ADDI rs1+sign-extended constant; 0010 SUB rs1-rs2; 0011 SHL rs1<<1; 0100 LT signed rs1<rs2 -> 1 else 0; 0101 EQ0 rs1==0 -> 1 else 0; 0110 CMP upper WIDTH/2 bits of rs1 equal upper WIDTH/2 bits of rs2 -> 1 else 0; 0111 XOR; 1000 AND; 1001 OR; 1010 NOT rs1; 1011 SHLN rs1 shifted left by rs2[$clog2(WIDTH)-1:0] (n).
REQ-018 Opcodes 1100-1111 SHALL produce aluOut 0, overflow 0, with normal single-cycle latency.
REQ-019 Results SHALL be truncated to WIDTH bits; 1-bit results zero-extended.
REQ-020 overflow SHALL be two's-complement signed overflow for ADD, ADDI, SUB; for SHL and SHLN it SHALL be 1 if the sign bit changed on any single-bit shift step; 0 for all other opcodes.
REQ-021 Single-cycle ops and SHLN with n=0: aluOut/overflow/out_valid SHALL update on the accept edge (latency 1).
REQ-022 FSM states IDLE, SHIFT. SHLN with n>=1: accept edge loads work=rs1, cnt=n, state SHIFT; each SHIFT edge work<<=1, cnt-=1; on the edge where cnt goes 1->0, write result to output register, out_valid=1, state IDLE. Latency n+1 edges.
REQ-023 in_ready SHALL be 0 throughout SHIFT; in_valid is ignored there.
REQ-024 Output register SHALL hold aluOut, overflow, out_valid stable while out_valid && !out_ready.
REQ-025 out_valid SHALL clear on an edge with out_valid && out_ready and no new result written; a new result written on the same edge SHALL replace it (throughput one per cycle).
REQ-026 sticky_ovf SHALL set on any edge writing a result with overflow=1; clr_sticky clears it; set SHALL win over simultaneous clear.
REQ-027 SHIFT with out_valid=1 and out_ready=0 at final step SHALL stall in SHIFT with cnt=1 until the output register is free.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, out_valid 0, aluOut 0, overflow 0, sticky_ovf 0, work 0, cnt 0.
REQ-029 Reset during SHIFT SHALL abort the operation with no result produced; in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-030 ADD rs1=0x04, rs2=0x01 -> aluOut 0x05, overflow 0, out_valid one edge after accept.
REQ-031 ADDI rs1=0x04, constant=2'b11 -> 0x03; ADD 0x7F+0x01 -> 0x80, overflow 1, sticky_ovf 1 until clr_sticky pulse.
REQ-032 LT rs1=0x01, rs2=0x84 -> 0x00; CMP rs1=0x00, rs2=0x40 -> 0x00; CMP rs1=0x00, rs2=0x00 -> 0x01; NOT 0x00 -> 0xFF.
REQ-033 SHLN rs1=0x03, rs2=3 -> 0x18, overflow 0, out_valid after 4 edges, in_ready 0 for 3 cycles; SHLN rs1=0x21, rs2=2 -> 0x84, overflow 1.
REQ-034 out_ready=0, issue ADD then XOR -> first result held, in_ready 0; raise out_ready -> ADD result then XOR result in order, none lost or duplicated.
REQ-035 rst_n pulsed low mid-SHLN (rs2=7) -> out_valid 0, sticky_ovf 0, in_ready 1 after release, no stray result.
